mips_mem_arbiter: RTL

//  Shares one single-port, variable-latency unified memory between the pipeline's fetch

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mem_wait_timer.sv | 38 +++
 rtl/mips_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the unified memory arbiter.
// Used by the arbiter RTL and by the testbench memory model.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IFETCH,
    DACC
  } arb_state_t;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  // Read data returned when a transaction is aborted by the wait timer.
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the last allowed one.
// Ports: clk, rst_n, clr_i (sync clear), en_i (count), expire_o (budget used up).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT_CYC-th unacknowledged cycle.
  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one variable-latency memory between fetch and data.
// Ports: clk/reset, IF req/addr/flush/rdata/valid, MEM req/we/addr/wdata/rdata/valid,
// stall_f/stall_m, registered memory bus mem_*, sticky timeout err.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int unsigned SW = $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_BURST);

  arb_state_t    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;

  logic          expire;
  logic          fin;
  logic          gnt_d;
  logic          gnt_i;
  logic [DW-1:0] rdata;

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (!mem_req_q),
    .en_i    (mem_req_q && !mem_ack),
    .expire_o(expire)
  );

  // Expiry is only possible while mem_req is up and no ack arrived.
  assign fin   = mem_ack || expire;
  assign rdata = mem_ack ? mem_rdata : DW'(ERR_RDATA);

  // Data wins unless it has starved a waiting fetch for a full burst.
  assign gnt_d = d_req && !(streak_q == SMAX && if_req);
  assign gnt_i = !gnt_d && if_req;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    done_d      = 1'b0;
    drop_d      = drop_q;
    err_d       = err_q;
    streak_d    = streak_q;
    unique case (state_q)
      IDLE: begin
        if (!if_req) begin
          streak_d = '0;
        end
        // The completion cycle never grants: the requester is still
        // holding its old request while it sees the valid pulse.
        if (!done_q) begin
          unique case (1'b1)
            gnt_d: begin
              state_d     = DACC;
              mem_req_d   = 1'b1;
              mem_we_d    = d_we;
              mem_addr_d  = d_addr;
              mem_wdata_d = d_wdata;
              if (if_req) begin
                streak_d = streak_q + 1'b1;
              end
            end
            gnt_i: begin
              state_d     = IFETCH;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_addr_d  = if_addr;
              mem_wdata_d = '0;
              streak_d    = '0;
            end
            default: ;
          endcase
        end
      end
      IFETCH: begin
        if (if_flush) begin
          drop_d = 1'b1;
        end
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          drop_d    = 1'b0;
          err_d     = err_q || !mem_ack;
          if (!(drop_q || if_flush)) begin
            if_valid_d = 1'b1;
            if_rdata_d = rdata;
          end
        end
      end
      DACC: begin
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = err_q || !mem_ack;
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign stall_f   = if_req && !if_valid_q;
  assign stall_m   = d_req && !d_valid_q;

endmodule
